// File: rtl/touch_poll_pkg.sv
// touch_poll_pkg: shared state type, coordinate width and default PIO addresses for the touch poller
package touch_poll_pkg;
  localparam int COORD_W = 12;
  localparam logic [31:0] X_ADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] Y_ADDR_DEF = 32'h0000_0010;
  typedef enum logic [2:0] {IDLE, RD_X, WT_X, RD_Y, WT_Y, PUB} state_t;
endpackage

// File: rtl/touch_avg4.sv
// touch_avg4: four-pair coordinate averager (accumulators, pair counter, divide by 4)
// Compiled only when TOUCH_POLL_AVG_EN is defined.
// Ports: clk, reset (async, active high); pair_ok pulses with a completed pair on x_in/y_in;
// clr discards a partial set; fire flags that this pair completes a set of four and
// x_avg/y_avg hold the truncated mean including the current pair.
`ifdef TOUCH_POLL_AVG_EN
module touch_avg4
  import touch_poll_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               pair_ok,
  input  logic               clr,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic [COORD_W-1:0] x_avg,
  output logic [COORD_W-1:0] y_avg,
  output logic               fire
);
  localparam int AW = COORD_W + 2;
  logic [AW-1:0] acc_x, acc_y, sum_x, sum_y;
  logic [1:0] cnt;
  assign sum_x = acc_x + AW'(x_in);
  assign sum_y = acc_y + AW'(y_in);
  assign x_avg = sum_x[AW-1:2];
  assign y_avg = sum_y[AW-1:2];
  assign fire = cnt == 2'd3;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_x <= '0;
      acc_y <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc_x <= '0;
      acc_y <= '0;
      cnt <= '0;
    end else if (pair_ok) begin
      acc_x <= fire ? '0 : sum_x;
      acc_y <= fire ? '0 : sum_y;
      cnt <= cnt + 2'd1;
    end
endmodule
`endif

// File: rtl/touch_pio_poller.sv
// touch_pio_poller: Avalon-MM initiator polling touch-panel X/Y PIOs and publishing coordinate pairs
// Ports: clk, reset (async, active high), enable (polling runs while high);
// avm_* Avalon-MM read initiator (address, read, waitrequest, readdata, readdatavalid);
// x_out/y_out last published pair, coord_valid one-cycle publish pulse,
// rd_err one-cycle timeout pulse, busy high outside IDLE.
// Option: define TOUCH_POLL_AVG_EN to publish the mean of every four completed pairs.
module touch_pio_poller
  import touch_poll_pkg::*;
#(
  parameter int unsigned POLL_DIV    = 50000,
  parameter logic [31:0] X_ADDR      = X_ADDR_DEF,
  parameter logic [31:0] Y_ADDR      = Y_ADDR_DEF,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  output logic [31:0]        avm_address,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [31:0]        avm_readdata,
  input  logic               avm_readdatavalid,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               coord_valid,
  output logic               rd_err,
  output logic               busy
);
  localparam int PW = $clog2(POLL_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);
  state_t state, state_n;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [COORD_W-1:0] x_tmp, rd_coord, pub_x, pub_y;
  logic wt, timed_out, got_x, got_y, pub_q, pub_fire;
  logic unused_rd;
  assign rd_coord = avm_readdata[COORD_W-1:0];
  assign unused_rd = ^avm_readdata[31:COORD_W];
  assign wt = state == WT_X || state == WT_Y;
  // timeout wins over a coincident valid so rd_err stays a pure decode of registers
  assign timed_out = wt && tmo_cnt == TMO_MAX;
  assign got_x = state == WT_X && !timed_out && avm_readdatavalid;
  assign got_y = state == WT_Y && !timed_out && avm_readdatavalid;
  assign avm_read = state == RD_X || state == RD_Y;
  assign avm_address = (state == RD_Y || state == WT_Y) ? Y_ADDR : X_ADDR;
  assign busy = state != IDLE;
  assign rd_err = timed_out;
  assign coord_valid = state == PUB && pub_q;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (enable && poll_cnt == '0) ? RD_X : IDLE;
      RD_X:    state_n = avm_waitrequest ? RD_X : WT_X;
      WT_X:    state_n = timed_out ? IDLE : got_x ? RD_Y : WT_X;
      RD_Y:    state_n = avm_waitrequest ? RD_Y : WT_Y;
      WT_Y:    state_n = timed_out ? IDLE : got_y ? PUB : WT_Y;
      default: state_n = IDLE;
    endcase
  end
`ifdef TOUCH_POLL_AVG_EN
  touch_avg4 u_avg (
    .clk     (clk),
    .reset   (reset),
    .pair_ok (got_y),
    .clr     (timed_out),
    .x_in    (x_tmp),
    .y_in    (rd_coord),
    .x_avg   (pub_x),
    .y_avg   (pub_y),
    .fire    (pub_fire)
  );
`else
  assign pub_fire = 1'b1;
  assign pub_x = x_tmp;
  assign pub_y = rd_coord;
`endif
  // x_out/y_out load on the edge entering PUB so they already hold the new pair while coord_valid is high
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      poll_cnt <= POLL_MAX;
      tmo_cnt <= '0;
      x_tmp <= '0;
      x_out <= '0;
      y_out <= '0;
      pub_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && enable) poll_cnt <= poll_cnt == '0 ? POLL_MAX : poll_cnt - PW'(1);
      tmo_cnt <= wt ? tmo_cnt + TW'(1) : '0;
      if (got_x) x_tmp <= rd_coord;
      if (got_y) begin
        pub_q <= pub_fire;
        if (pub_fire) begin
          x_out <= pub_x;
          y_out <= pub_y;
        end
      end
    end
endmodule

// File: doc/touch_pio_poller.md
# touch_pio_poller

Avalon-MM initiator that periodically reads the touch-panel X and Y coordinate PIO responders and presents each coordinate pair as a registered, single-cycle-validated sample. It sits between the system interconnect and the handwriting-capture logic, so hardware can track the pen without Nios II polling. Each poll is two reads, X then Y, with waitrequest/readdatavalid handshaking and a per-read timeout.

## Interface
- POLL_DIV, 50000: clk cycles between poll starts; legal range ≥ 8.
- X_ADDR, 32'h0000_0000: byte address of the X coordinate PIO data register.
- Y_ADDR, 32'h0000_0010: byte address of the Y coordinate PIO data register.
- TIMEOUT_CYC, 16: maximum cycles spent waiting for readdatavalid after a read is accepted.
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; polling runs while high.
- avm_address  out  32  read address, either X_ADDR or Y_ADDR.
- avm_read  out  1  read request; held until accepted.
- avm_waitrequest  in  1  interconnect stall.
- avm_readdata  in  32  read data; only bits [11:0] used.
- avm_readdatavalid  in  1  qualifies avm_readdata.
- x_out  out  12  last published X.
- y_out  out  12  last published Y.
- coord_valid  out  1  one-cycle pulse when x_out/y_out update.
- rd_err  out  1  one-cycle pulse on timeout.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, RD_X, WT_X, RD_Y, WT_Y, PUB.
- IDLE:
  - The poll counter counts down from POLL_DIV-1 to 0 while enable is high, then reloads.
  - At 0 with enable high, go to RD_X.
  - If enable is low, the counter holds its value.
- RD_X:
  - avm_read=1, avm_address=X_ADDR.
  - Stay while avm_waitrequest=1.
  - On an accepted cycle (read=1, waitrequest=0), go to WT_X and clear the timeout counter.
- WT_X:
  - avm_read=0.
  - On avm_readdatavalid, capture avm_readdata[11:0] into x_tmp and go to RD_Y.
  - The timeout counter increments each cycle without valid. When it reaches TIMEOUT_CYC, go to IDLE, pulse rd_err, discard x_tmp; no coord_valid.
- RD_Y and WT_Y: identical to RD_X and WT_X, using Y_ADDR and y_tmp. On valid, go to PUB.
- PUB:
  - x_out<=x_tmp, y_out<=y_tmp, coord_valid=1 for exactly this cycle.
  - Go to IDLE.
- enable dropping mid-poll: the pair in flight completes, including PUB. The block then halts in IDLE.
- avm_readdatavalid outside WT_X/WT_Y (including in IDLE after a timeout) is ignored.
- Reset mid-operation:
  - avm_read drops immediately (asynchronous).
  - The state returns to IDLE and the poll counter reloads POLL_DIV-1.
  - Any outstanding response is ignored.

## Timing
- Reset values:
  - avm_read=0, avm_address=X_ADDR.
  - x_out=0, y_out=0.
  - coord_valid=0, rd_err=0, busy=0.
  - The poll counter holds POLL_DIV-1.
- All outputs are registered or decoded from the state register only; there is no combinational path from any input to any output.
- Zero-wait case with 1-cycle read latency:
  - cycle 0: RD_X
  - cycle 1: WT_X, valid
  - cycle 2: RD_Y
  - cycle 3: WT_Y, valid
  - cycle 4: PUB, coord_valid=1
  - Latency from poll start is 5 cycles.
- Poll period is POLL_DIV cycles counted in IDLE, so the effective period is POLL_DIV + transaction length.
- A timeout asserts rd_err in the cycle the counter equals TIMEOUT_CYC; the next cycle is IDLE.

## Configuration
- TOUCH_POLL_AVG_EN defined:
  - Each completed pair adds into 14-bit X and Y accumulators.
  - Every 4th completed pair publishes acc>>2 (truncating) with coord_valid, then clears the accumulators.
  - A timeout clears the accumulators and the pair count.
- TOUCH_POLL_AVG_EN undefined:
  - Every completed pair publishes directly.
  - No accumulator logic is present.

## Structure
- Shared package touch_poll_pkg holds:
  - the state enum type (IDLE..PUB);
  - the coordinate width constant COORD_W=12;
  - the default address constants.
- Sub-module touch_avg4 holds the accumulators, the 2-bit pair counter and the divide. It is instantiated only under TOUCH_POLL_AVG_EN.

## Test plan
- Zero wait, latency 1, X slave returns 32'h0000_0ABC, Y returns 32'h0000_0123, POLL_DIV=8 -> coord_valid pulses once with x_out=12'hABC, y_out=12'h123, 5 cycles after read first asserted.
- avm_waitrequest held high 3 cycles in RD_X -> avm_read and avm_address=X_ADDR stable all 4 cycles; exactly one X read accepted.
- No readdatavalid for the Y read, TIMEOUT_CYC=16 -> rd_err pulses once, no coord_valid, x_out/y_out keep prior values, next poll proceeds normally.
- enable dropped during WT_X -> pair completes with coord_valid, then avm_read stays 0 for 3×POLL_DIV cycles.
- reset asserted during RD_Y -> avm_read=0 in the same cycle, outputs return to reset values, and the first read after release occurs POLL_DIV cycles later.
- With TOUCH_POLL_AVG_EN defined, X samples 100, 101, 102, 104 -> a single coord_valid after the 4th pair with x_out=101.
